// File: rtl/seq_slice_adder.sv
// Multi-cycle adder/subtractor: one SLICE-bit ripple slice per clock, LSB first, with valid/ready on both sides.
// Define SEQ_SLICE_ADDER_SAT_EN to saturate S to the signed limit on overflow.
module seq_slice_adder #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             C_out,
  output logic             V,
  output logic             Z
);

  localparam int NSL = WIDTH / SLICE;
  localparam int IW  = (NSL > 1) ? $clog2(NSL) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, s_next;
  logic             carry;
  logic [IW-1:0]    idx;
  logic [SLICE:0]   slice_sum;
  logic             last_slice;
  logic             v_next;

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign last_slice = (idx == IW'(NSL - 1));

  // Carry into the MSB is recovered as a^b^s at that bit, so V needs no extra adder tap.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    slice_sum = {1'b0, a_reg[idx*SLICE +: SLICE]}
              + {1'b0, b_reg[idx*SLICE +: SLICE]}
              + {{SLICE{1'b0}}, carry};
    s_next = S;
    s_next[idx*SLICE +: SLICE] = slice_sum[SLICE-1:0];
    v_next = a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ s_next[WIDTH-1] ^ slice_sum[SLICE];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)   state_next = RUN;
      RUN:     if (last_slice) state_next = DONE;
      DONE:    if (out_ready)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      idx   <= '0;
      S     <= '0;
      C_out <= 1'b0;
      V     <= 1'b0;
      Z     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_reg <= A;
          b_reg <= sub ? ~B : B;
          carry <= sub ? ~C_in : C_in;
          idx   <= '0;
        end
        RUN: begin
          S     <= s_next;
          carry <= slice_sum[SLICE];
          idx   <= idx + 1'b1;
          if (last_slice) begin
            C_out <= slice_sum[SLICE];
            V     <= v_next;
            Z     <= (s_next == '0);
`ifdef SEQ_SLICE_ADDER_SAT_EN
            if (v_next)
              S <= a_reg[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_slice_adder.sv
// Directed self-checking bench for seq_slice_adder (WIDTH=16, SLICE=4).
module tb_seq_slice_adder;

  localparam int WIDTH = 16;
  localparam int SLICE = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] A, B, S;
  logic             C_in, sub;
  logic             out_valid, out_ready;
  logic             C_out, V, Z;

  int checks   = 0;
  int failures = 0;

  seq_slice_adder #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .C_in(C_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .S(S), .C_out(C_out), .V(V), .Z(Z)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present operands for one edge, then count edges until out_valid rises.
  task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic ci,
                        input logic sb, input string tag);
    int n;
    @(negedge clk);
    A = a; B = b; C_in = ci; sub = sb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = 16'hDEAD; B = 16'hBEEF;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, ".latency"}, n, 4);
  endtask

  task automatic expect_result(input string tag, input logic [15:0] s, input logic c,
                               input logic v, input logic z);
    check({tag, ".S"}, S, s);
    check({tag, ".C_out"}, C_out, c);
    check({tag, ".V"}, V, v);
    check({tag, ".Z"}, Z, z);
  endtask

  task automatic release_result(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".out_valid_drop"}, out_valid, 0);
    check({tag, ".in_ready_back"}, in_ready, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; C_in = 1'b0; sub = 1'b0;
    #12;
    check("reset.in_ready", in_ready, 1);
    check("reset.out_valid", out_valid, 0);
    expect_result("reset", 16'h0000, 0, 0, 0);
    @(negedge clk); rst = 1'b0;

    launch(16'h1234, 16'h4321, 0, 0, "add_basic");
    expect_result("add_basic", 16'h5555, 0, 0, 0);
    // Backpressure: hold out_ready low with a competing request pending.
    @(negedge clk);
    in_valid = 1'b1; A = 16'h0F0F; B = 16'h0F0F;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp.out_valid", out_valid, 1);
      check("bp.in_ready", in_ready, 0);
      expect_result("bp", 16'h5555, 0, 0, 0);
    end
    @(negedge clk); in_valid = 1'b0;
    release_result("bp");
    check("bp.no_new_op", S, 16'h5555);

    launch(16'hFFFF, 16'h0001, 0, 0, "add_carry");
    expect_result("add_carry", 16'h0000, 1, 0, 1);
    release_result("add_carry");

    launch(16'h7FFF, 16'h0001, 0, 0, "add_ovf");
`ifdef SEQ_SLICE_ADDER_SAT_EN
    expect_result("add_ovf", 16'h7FFF, 0, 1, 0);
`else
    expect_result("add_ovf", 16'h8000, 0, 1, 0);
`endif
    release_result("add_ovf");

    launch(16'h0005, 16'h0007, 0, 1, "sub_neg");
    expect_result("sub_neg", 16'hFFFE, 0, 0, 0);
    release_result("sub_neg");

    launch(16'h0007, 16'h0005, 1, 1, "sub_borrow");
    expect_result("sub_borrow", 16'h0001, 1, 0, 0);
    release_result("sub_borrow");

    // Abort mid-RUN after slice 2 with an operation that would leave upper-slice residue.
    @(negedge clk);
    A = 16'hABCD; B = 16'h1111; C_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort.in_ready", in_ready, 1);
    check("abort.out_valid", out_valid, 0);
    expect_result("abort", 16'h0000, 0, 0, 0);
    @(negedge clk); rst = 1'b0;

    launch(16'h0001, 16'h0001, 0, 0, "post_abort");
    expect_result("post_abort", 16'h0002, 0, 0, 0);
    release_result("post_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
